// File: rtl/multimode_ring_counter.sv
// Width-parametrised ring / Johnson sequencer with load, illegal-state correction,
// a wrap pulse and a free-running wrap counter.
module multimode_ring_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err,
  output logic [CNT_W-1:0] wrap_cnt
);

  localparam logic [1:0] MODE_JOHNSON = 2'b01;

  logic [WIDTH-1:0] count_q, count_d, start, rot;
  logic [WIDTH-2:0] diff;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             wrap_q, wrap_d, err_q, err_d;
  logic             is_johnson, legal, step, fb;

  always_comb begin
    is_johnson = (mode == MODE_JOHNSON);
    start      = is_johnson ? '0 : WIDTH'(1);
    // Johnson states have at most one 0/1 boundary between adjacent bits.
    diff       = count_q[WIDTH-1:1] ^ count_q[WIDTH-2:0];
    legal      = is_johnson ? $onehot0(diff) : $onehot(count_q);
    if (dir) begin
      fb  = is_johnson ? ~count_q[WIDTH-1] : count_q[WIDTH-1];
      rot = {count_q[WIDTH-2:0], fb};
    end else begin
      fb  = is_johnson ? ~count_q[0] : count_q[0];
      rot = {fb, count_q[WIDTH-1:1]};
    end
    step = en && !mode[1];

    count_d    = count_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      if (legal) begin
        count_d = rot;
        if (rot == start) begin
          wrap_d     = 1'b1;
          wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
        end
      end else begin
        count_d = start;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= WIDTH'(1);
      wrap_cnt_q <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_cnt_q <= wrap_cnt_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign err      = err_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Bench for multimode_ring_counter: a WIDTH=4 and a WIDTH=8/CNT_W=2 instance checked
// against a sequence-table reference model.
module tb_multimode_ring_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r4, e4, d4, l4, w4, er4;
  logic [1:0] m4;
  logic [3:0] lv4, c4;
  logic [7:0] wc4;
  logic       r8, e8, d8, l8, w8, er8;
  logic [1:0] m8;
  logic [7:0] lv8, c8;
  logic [1:0] wc8;

  multimode_ring_counter #(.WIDTH(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(r4), .en(e4), .mode(m4), .dir(d4), .load(l4), .load_val(lv4),
    .count(c4), .wrap(w4), .err(er4), .wrap_cnt(wc4)
  );

  multimode_ring_counter #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .reset(r8), .en(e8), .mode(m8), .dir(d8), .load(l8), .load_val(lv8),
    .count(c8), .wrap(w8), .err(er8), .wrap_cnt(wc8)
  );

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mc4 = '0, mc8 = '0;
  logic        mw4 = 1'b0, me4 = 1'b0, mw8 = 1'b0, me8 = 1'b0;
  int          mwc4 = 0, mwc8 = 0;

  // k-th state of the mode's sequence, index 0 being the start state.
  function automatic logic [31:0] state_at(input int w, input logic [1:0] md, input int k);
    logic [31:0] one = 32'd1;
    if (md == 2'b00) return one << k;
    if (k <= w) return ((one << k) - 1) << (w - k);
    return (one << (w - (k - w))) - 1;
  endfunction

  task automatic model_step(input int w, input int cw, input logic rst, input logic ld,
                            input logic [31:0] lv, input logic e, input logic [1:0] md,
                            input logic dr, input logic [31:0] c, input int wc,
                            output logic [31:0] nc, output logic nw, output logic ne,
                            output int nwc);
    int k, p, nk;
    nc = c; nw = 1'b0; ne = 1'b0; nwc = wc;
    if (rst) begin
      nc = 32'd1; nwc = 0;
    end else if (ld) begin
      nc = lv;
    end else if (e && md < 2) begin
      p = (md == 2'b01) ? 2 * w : w;
      k = -1;
      for (int i = 0; i < p; i++) if (state_at(w, md, i) == c) k = i;
      if (k < 0) begin
        nc = state_at(w, md, 0); ne = 1'b1;
      end else begin
        // Ring left and Johnson right walk the table forward.
        nk = ((md == 2'b00) == (dr == 1'b1)) ? (k + 1) % p : (k + p - 1) % p;
        nc = state_at(w, md, nk);
        if (nk == 0) begin
          nw = 1'b1; nwc = (wc + 1) % (1 << cw);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(4, 8, r4, l4, {28'd0, lv4}, e4, m4, d4, mc4, mwc4, mc4, mw4, me4, mwc4);
    model_step(8, 2, r8, l8, {24'd0, lv8}, e8, m8, d8, mc8, mwc8, mc8, mw8, me8, mwc8);
    #1;
  endtask

  task automatic idle4();
    r4 = 0; e4 = 0; l4 = 0; d4 = 0; m4 = 2'b00; lv4 = '0;
  endtask

  task automatic test_reset();
    r4 = 1; r8 = 1; e4 = 1; l4 = 1; lv4 = 4'b1111; m4 = 2'b01;
    tick();
    compared++;
    if ({c4, w4, er4, wc4} !== {4'b0001, 1'b0, 1'b0, 8'd0}) begin
      mismatched++;
      $display("FAIL reset4: got c=%b w=%b e=%b wc=%0d want c=0001 w=0 e=0 wc=0",
               c4, w4, er4, wc4);
    end
    compared++;
    if ({c8, w8, er8, wc8} !== {8'b0000_0001, 1'b0, 1'b0, 2'd0}) begin
      mismatched++;
      $display("FAIL reset8: got c=%b w=%b e=%b wc=%0d", c8, w8, er8, wc8);
    end
    r4 = 0; r8 = 0; idle4();
  endtask

  task automatic test_ring_right();
    m4 = 2'b00; d4 = 0; e4 = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      compared++;
      if ({c4, w4, er4, wc4} !== {mc4[3:0], mw4, me4, mwc4[7:0]}) begin
        mismatched++;
        $display("FAIL ring_right[%0d]: got c=%b w=%b e=%b wc=%0d want c=%b w=%b e=%b wc=%0d",
                 i, c4, w4, er4, wc4, mc4[3:0], mw4, me4, mwc4);
      end
    end
    compared++;
    if (wc4 !== 8'd2) begin
      mismatched++;
      $display("FAIL ring_right_wcnt: got %0d want 2", wc4);
    end
  endtask

  task automatic test_ring_left();
    m4 = 2'b00; d4 = 1;
    for (int i = 0; i < 16; i++) begin
      e4 = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      compared++;
      if ({c4, w4, er4, wc4} !== {mc4[3:0], mw4, me4, mwc4[7:0]}) begin
        mismatched++;
        $display("FAIL ring_left[%0d]: got c=%b w=%b e=%b wc=%0d want c=%b w=%b e=%b wc=%0d",
                 i, c4, w4, er4, wc4, mc4[3:0], mw4, me4, mwc4);
      end
      if (i == 3) begin
        compared++;
        if ({c4, w4} !== {4'b0001, 1'b1}) begin
          mismatched++;
          $display("FAIL ring_left_wrap: got c=%b w=%b want c=0001 w=1", c4, w4);
        end
      end
    end
  endtask

  task automatic test_johnson();
    int wc0;
    m4 = 2'b01; l4 = 1; lv4 = 4'b0000; e4 = 1;
    tick();
    l4 = 0; d4 = 0; wc0 = int'(wc4);
    for (int i = 0; i < 8; i++) begin
      tick();
      compared++;
      if ({c4, w4, er4, wc4} !== {mc4[3:0], mw4, me4, mwc4[7:0]} || w4 !== (i == 7)) begin
        mismatched++;
        $display("FAIL johnson[%0d]: got c=%b w=%b e=%b wc=%0d want c=%b w=%b e=%b wc=%0d",
                 i, c4, w4, er4, wc4, mc4[3:0], mw4, me4, mwc4);
      end
    end
    compared++;
    if ({c4, int'(wc4)} !== {4'b0000, wc0 + 1}) begin
      mismatched++;
      $display("FAIL johnson_end: got c=%b wc=%0d want c=0000 wc=%0d", c4, wc4, wc0 + 1);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] wc0;
    for (int md = 0; md < 2; md++) begin
      m4 = 2'(md); e4 = 0; l4 = 1; lv4 = 4'b0101;
      tick();
      l4 = 0; e4 = 1; wc0 = wc4;
      tick();
      compared++;
      if ({c4, w4, er4, wc4} !== {(md == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b1, wc0}) begin
        mismatched++;
        $display("FAIL illegal_mode%0d: got c=%b w=%b e=%b wc=%0d want err=1 wc=%0d",
                 md, c4, w4, er4, wc4, wc0);
      end
    end
    // Legal Johnson 0011 becomes illegal once the mode switches to ring.
    m4 = 2'b01; e4 = 0; l4 = 1; lv4 = 4'b0011;
    tick();
    l4 = 0; e4 = 1; m4 = 2'b00;
    tick();
    compared++;
    if ({c4, er4} !== {4'b0001, 1'b1}) begin
      mismatched++;
      $display("FAIL mode_change: got c=%b e=%b want c=0001 e=1", c4, er4);
    end
  endtask

  task automatic test_priority();
    m4 = 2'b00; e4 = 1; l4 = 1; lv4 = 4'b0100;
    tick();
    compared++;
    if (c4 !== 4'b0100) begin
      mismatched++;
      $display("FAIL load_over_en: got c=%b want c=0100", c4);
    end
    r4 = 1; lv4 = 4'b1111;
    tick();
    r4 = 0; l4 = 0;
    compared++;
    if ({c4, wc4} !== {4'b0001, 8'd0}) begin
      mismatched++;
      $display("FAIL reset_over_load: got c=%b wc=%0d want c=0001 wc=0", c4, wc4);
    end
    m4 = 2'b01; l4 = 1; lv4 = 4'b0000; d4 = 0;
    tick();
    l4 = 0;
    for (int i = 0; i < 3; i++) tick();
    compared++;
    if (c4 !== 4'b1110) begin
      mismatched++;
      $display("FAIL johnson_pre_reset: got c=%b want c=1110", c4);
    end
    r4 = 1;
    tick();
    r4 = 0;
    compared++;
    if ({c4, w4, er4} !== {4'b0001, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid_johnson: got c=%b w=%b e=%b want c=0001", c4, w4, er4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      r4 = ($urandom_range(0, 40) == 0);
      l4 = ($urandom_range(0, 9) == 0);
      e4 = ($urandom_range(0, 3) != 0);
      m4 = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      d4 = 1'($urandom_range(0, 1));
      lv4 = 4'($urandom);
      tick();
      compared++;
      if ({c4, w4, er4, wc4} !== {mc4[3:0], mw4, me4, mwc4[7:0]} || (w4 && er4)) begin
        mismatched++;
        $display("FAIL random[%0d]: got c=%b w=%b e=%b wc=%0d want c=%b w=%b e=%b wc=%0d",
                 i, c4, w4, er4, wc4, mc4[3:0], mw4, me4, mwc4);
      end
    end
    idle4();
  endtask

  task automatic test_wide();
    logic [7:0] held;
    r8 = 1;
    tick();
    r8 = 0; m8 = 2'b00; d8 = 0; e8 = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      compared++;
      if ({c8, w8, er8, wc8} !== {mc8[7:0], mw8, me8, mwc8[1:0]}) begin
        mismatched++;
        $display("FAIL wide[%0d]: got c=%b w=%b e=%b wc=%0d want c=%b w=%b e=%b wc=%0d",
                 i, c8, w8, er8, wc8, mc8[7:0], mw8, me8, mwc8);
      end
    end
    compared++;
    if ({c8, wc8} !== {8'b0000_0001, 2'd1}) begin
      mismatched++;
      $display("FAIL wide_rollover: got c=%b wc=%0d want c=00000001 wc=1", c8, wc8);
    end
    m8 = 2'b10; held = c8;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if ({c8, w8, er8, wc8} !== {held, 1'b0, 1'b0, 2'd1}) begin
        mismatched++;
        $display("FAIL wide_hold[%0d]: got c=%b w=%b wc=%0d want c=%b w=0 wc=1",
                 i, c8, w8, wc8, held);
      end
    end
    e8 = 0; m8 = 2'b00;
  endtask

  initial begin
    idle4();
    r8 = 0; e8 = 0; d8 = 0; l8 = 0; m8 = 2'b00; lv8 = '0;
    test_reset();
    test_ring_right();
    test_ring_left();
    test_johnson();
    test_illegal();
    test_priority();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
